// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational 32-bit ALU
//
// Purpose: grants one of two requesters (0: pipeline EX, 1: aux/debug) access
// to an external combinational ALU, registers the operands, and returns the
// registered result to the owner with a valid/ready handshake.
// Optional feature: define ALU_ARB_OVF_EN to compute signed overflow for
// add (0x20) / sub (0x22); otherwise rspN_ovf is tied 0.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/ready                request handshake (N = 0,1)
//   reqN_a/b/shamt/op               request operands and ALU funct opcode
//   rspN_valid/ready                response handshake
//   rspN_data/err/ovf               shared result, illegal-op flag, overflow flag
//   alu_a/b/shamt/op                operands driven to the ALU (from registers)
//   alu_out                         ALU result

module alu_arbiter #(
    parameter int PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_shamt,
    input  logic [5:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_shamt,
    input  logic [5:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_data,
    output logic        rsp0_err,
    output logic        rsp0_ovf,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_data,
    output logic        rsp1_err,
    output logic        rsp1_ovf,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [5:0]  alu_op,
    input  logic [31:0] alu_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q;
    logic        owner_q;
    logic [31:0] a_q, b_q, result_q;
    logic [4:0]  shamt_q;
    logic [5:0]  op_q;
    logic        err_q;
    logic        grant;
    logic        accept;
    logic        op_legal;
    logic        ovf_w;

    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b: op_legal = 1'b1;
            default:      op_legal = 1'b0;
        endcase
    end

    // Grant is only meaningful when at least one requester is valid; with a
    // single valid requester it simply names that requester.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: state_d = S_RESP;
            S_RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            shamt_q      <= '0;
            op_q         <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                a_q          <= grant ? req1_a     : req0_a;
                b_q          <= grant ? req1_b     : req0_b;
                shamt_q      <= grant ? req1_shamt : req0_shamt;
                op_q         <= grant ? req1_op    : req0_op;
            end
            if (state_q == S_EXEC) begin
                err_q    <= ~op_legal;
                result_q <= op_legal ? alu_out : 32'h0;
            end
        end
    end

`ifdef ALU_ARB_OVF_EN
    logic ovf_q;
    logic b_eff_sign;
    logic ovf_calc;

    // For sub the second operand's effective sign is inverted (a + ~b + 1).
    always_comb begin
        b_eff_sign = (op_q == 6'h22) ? ~b_q[31] : b_q[31];
        ovf_calc   = ((op_q == 6'h20) || (op_q == 6'h22)) &&
                     (a_q[31] == b_eff_sign) && (alu_out[31] != a_q[31]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_EXEC) begin
            ovf_q <= ovf_calc;
        end
    end

    assign ovf_w = ovf_q;
`else
    assign ovf_w = 1'b0;
`endif

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_shamt = shamt_q;
    assign alu_op    = op_q;
    assign rsp0_data = result_q;
    assign rsp1_data = result_q;
    assign rsp0_err  = err_q;
    assign rsp1_err  = err_q;
    assign rsp0_ovf  = ovf_w;
    assign rsp1_ovf  = ovf_w;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter

module tb_alu_arbiter;

    localparam int PRIO = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [5:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_err, rsp1_err, rsp0_ovf, rsp1_ovf;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_shamt;
    logic [5:0]  alu_op;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_FIXED(PRIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_err(rsp0_err), .rsp0_ovf(rsp0_ovf),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_err(rsp1_err), .rsp1_ovf(rsp1_ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_op(alu_op),
        .alu_out(alu_out)
    );

    logic [5:0] legal_ops [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                   6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // External ALU: funct-encoded, fixed shifts by shamt, variable shifts by b[4:0].
    function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, b,
                                          input logic [4:0] sh);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            6'h00: return a << sh;
            6'h02: return a >> sh;
            6'h03: return sa >>> sh;
            6'h04: return a << b[4:0];
            6'h06: return a >> b[4:0];
            6'h07: return sa >>> b[4:0];
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2a: return {31'd0, sa < $signed(b)};
            6'h2b: return {31'd0, a < b};
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_op, alu_a, alu_b, alu_shamt);

    function automatic logic exp_ovf_f(input logic [5:0] op, input logic [31:0] a, b);
`ifdef ALU_ARB_OVF_EN
        longint s;
        longint lim;
        lim = 64'sd2147483647;
        if (op == 6'h20) s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 6'h22) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return (s > lim) || (s < -lim - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight; m_stage counts cycles since accept
    // (0 = free, 1 = computing, 2 = result presented until consumed).
    int          m_stage;
    bit          m_last, m_own;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_sh;
    logic [5:0]  m_op;

    function automatic bit exp_grant();
        if (req0_valid && req1_valid) return (PRIO != 0) ? 1'b0 : !m_last;
        return req1_valid;
    endfunction

    function automatic bit exp_ready(input int n);
        if (m_stage != 0) return 1'b0;
        if (n == 0) return req0_valid && !exp_grant();
        return req1_valid && exp_grant();
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_stage = 0; m_last = 1'b1; m_own = 1'b0;
            m_a = '0; m_b = '0; m_sh = '0; m_op = '0;
        end else if (m_stage == 0) begin
            if (req0_valid || req1_valid) begin
                m_own  = exp_grant();
                m_last = m_own;
                m_a    = m_own ? req1_a : req0_a;
                m_b    = m_own ? req1_b : req0_b;
                m_sh   = m_own ? req1_shamt : req0_shamt;
                m_op   = m_own ? req1_op : req0_op;
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            m_stage = 2;
        end else if (m_own ? rsp1_ready : rsp0_ready) begin
            m_stage = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] ed;
            ed = is_legal(m_op) ? alu_f(m_op, m_a, m_b, m_sh) : 32'h0;
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, exp_ready(0)});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, exp_ready(1)});
            chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_stage == 2 && !m_own});
            chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_stage == 2 && m_own});
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_shamt", {27'd0, alu_shamt}, {27'd0, m_sh});
            chk("alu_op", {26'd0, alu_op}, {26'd0, m_op});
            if (m_stage == 2) begin
                chk("rsp0_data", rsp0_data, ed);
                chk("rsp1_data", rsp1_data, ed);
                chk("rsp_err", {30'd0, rsp0_err, rsp1_err}, {30'd0, {2{!is_legal(m_op)}}});
                chk("rsp_ovf", {30'd0, rsp0_ovf, rsp1_ovf}, {30'd0, {2{exp_ovf_f(m_op, m_a, m_b)}}});
            end
        end
    end

    task automatic drive_req(input int n, input logic [5:0] op, input logic [31:0] a, b,
                             input logic [4:0] sh);
        if (n == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
        end
    endtask

    // sel: 0 req0_ready, 1 req1_ready, 2 rsp0_valid, 3 rsp1_valid; returns at a negedge.
    task automatic wait_high(input int sel, input string nm, output int cyc);
        logic s;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            s = (sel == 0) ? req0_ready : (sel == 1) ? req1_ready :
                (sel == 2) ? rsp0_valid : rsp1_valid;
        end while (!s && cyc < 20);
        if (!s) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input int n, input logic [5:0] op, input logic [31:0] a, b,
                          input logic [4:0] sh, output logic [31:0] d, output logic e,
                          output logic o, output int lat);
        int c;
        @(posedge clk); #1;
        drive_req(n, op, a, b, sh);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        wait_high(n, "accept", c);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_high(n + 2, "response", lat);
        d = n ? rsp1_data : rsp0_data;
        e = n ? rsp1_err : rsp0_err;
        o = n ? rsp1_ovf : rsp0_ovf;
    endtask

    logic [31:0] d;
    logic        e, o;
    int          lat, c;
    int          order[$];
    logic        exp_ov;

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_shamt = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_shamt = 0; req1_op = 0;
`ifdef ALU_ARB_OVF_EN
        exp_ov = 1'b1;
`else
        exp_ov = 1'b0;
`endif
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t1_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("t1_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        chk("t1_alu_ab", alu_a | alu_b, 32'd0);
        chk("t1_alu_op", {26'd0, alu_op}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(0, 6'h20, 32'd5, 32'd7, 5'd0, d, e, o, lat);
        chk("t2_latency", lat, 32'd2);
        chk("t2_data", d, 32'd12);
        chk("t2_err", {31'd0, e}, 32'd0);

        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        drive_req(0, 6'h2b, 32'd1, 32'hFFFFFFFF, 5'd0);
        drive_req(1, 6'h03, 32'h80000000, 32'd0, 5'd4);
        repeat (14) begin
            @(negedge clk);
            if (rsp0_valid) begin order.push_back(0); chk("t3_sltu", rsp0_data, 32'd1); end
            if (rsp1_valid) begin order.push_back(1); chk("t3_sra", rsp1_data, 32'hF8000000); end
        end
        chk("t3_count_ge4", {31'd0, order.size() >= 4}, 32'd1);
        if (order.size() >= 4)
            chk("t3_order", {28'd0, order[0][0], order[1][0], order[2][0], order[3][0]}, 32'b0101);
        @(posedge clk); #1; req0_valid = 0; req1_valid = 0;
        repeat (4) @(posedge clk);

        #1;
        drive_req(1, 6'h20, 32'd3, 32'd4, 5'd0);
        rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        wait_high(1, "t4_accept", c);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        drive_req(0, 6'h20, 32'd1, 32'd1, 5'd0);
        wait_high(3, "t4_response", c);
        chk("t4_data0", rsp1_data, 32'd7);
        repeat (5) begin
            @(negedge clk);
            chk("t4_valid_held", {31'd0, rsp1_valid}, 32'd1);
            chk("t4_data_held", rsp1_data, 32'd7);
            chk("t4_req0_blocked", {31'd0, req0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1; req0_valid = 1'b0;
        repeat (3) @(posedge clk);

        run_op(0, 6'h3F, 32'd9, 32'd9, 5'd0, d, e, o, lat);
        chk("t5_err", {31'd0, e}, 32'd1);
        chk("t5_data", d, 32'd0);
        run_op(1, 6'h21, 32'd2, 32'd3, 5'd0, d, e, o, lat);
        chk("t5_next_latency", lat, 32'd2);
        chk("t5_next_data", d, 32'd5);

        run_op(0, 6'h20, 32'h7FFFFFFF, 32'd1, 5'd0, d, e, o, lat);
        chk("t6_add_data", d, 32'h80000000);
        chk("t6_add_ovf", {31'd0, o}, {31'd0, exp_ov});
        run_op(1, 6'h21, 32'h7FFFFFFF, 32'd1, 5'd0, d, e, o, lat);
        chk("t6_addu_data", d, 32'h80000000);
        chk("t6_addu_ovf", {31'd0, o}, 32'd0);
        run_op(0, 6'h22, 32'h80000000, 32'd1, 5'd0, d, e, o, lat);
        chk("t6_sub_data", d, 32'h7FFFFFFF);
        chk("t6_sub_ovf", {31'd0, o}, {31'd0, exp_ov});

        @(posedge clk); #1;
        drive_req(0, 6'h20, 32'd1, 32'd1, 5'd0);
        wait_high(0, "t6_rst_accept", c);
        @(posedge clk); #1;
        req0_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_rst_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        end

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 199) != 0);
            req0_valid = $urandom_range(0, 1);
            req1_valid = $urandom_range(0, 1);
            req0_op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 15)];
            req1_op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 15)];
            req0_a = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
            req1_a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            req0_b = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
            req1_b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            req0_shamt = 5'($urandom);
            req1_shamt = 5'($urandom);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
